// File: rtl/mips_state_dumper.sv
// mips_state_dumper
// Streams the architectural state of a small MIPS core: r0..r31 from the
// register file, then a window of data memory, over a valid/ready port.
module mips_state_dumper #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic [4:0]        reg_rd_addr,
    input  logic [WORD_W-1:0] reg_rd_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_REG_CAP | register file addressed, capture read data
    // S_REG_OUT | register word presented, wait for handshake
    // S_MEM_RD  | one-cycle memory read strobe
    // S_MEM_CAP | capture memory read data
    // S_MEM_OUT | memory word presented, wait for handshake
    // S_DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_REG_CAP, S_REG_OUT, S_MEM_RD, S_MEM_CAP, S_MEM_OUT, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [4:0]        idx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [WORD_W-1:0] data_q;
    logic              xfer;

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    assign xfer = out_valid & out_ready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_REG_CAP;
            S_REG_CAP: state_nx = S_REG_OUT;
            S_REG_OUT: begin
                if (xfer) begin
                    if (idx != 5'd31)     state_nx = S_REG_CAP;
                    else if (cnt == '0)   state_nx = S_DONE;
                    else                  state_nx = S_MEM_RD;
                end
            end
            S_MEM_RD:  state_nx = S_MEM_CAP;
            S_MEM_CAP: state_nx = S_MEM_OUT;
            S_MEM_OUT: begin
                if (xfer) begin
                    if (cnt == CNT_ONE) state_nx = S_DONE;
                    else                state_nx = S_MEM_RD;
                end
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // datapath: register index, memory address, remaining count, word buffer.
    // addr and cnt double as the latched base and length of the dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            addr   <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        addr <= dump_base;
                        cnt  <= dump_len;
                    end
                end
                S_REG_CAP: data_q <= reg_rd_data;
                S_REG_OUT: if (xfer && idx != 5'd31) idx <= idx + 5'd1;
                S_MEM_CAP: data_q <= mem_rd_data;
                S_MEM_OUT: begin
                    if (xfer) begin
                        cnt  <= cnt - 1'b1;
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // output decode
    always_comb begin
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = addr;
        reg_rd_addr = idx;
        out_data    = data_q;
        case (state)
            S_REG_OUT: begin
                out_valid = 1'b1;
                out_last  = (idx == 5'd31) && (cnt == '0);
            end
            S_MEM_OUT: begin
                out_valid = 1'b1;
                out_last  = (cnt == CNT_ONE);
            end
            S_MEM_RD:  mem_rd_en = 1'b1;
            S_DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_state_dumper.sv
// tb_mips_state_dumper
// Scoreboard bench: expected words are queued when a dump is started and
// popped by a monitor on every observed handshake.
module tb_mips_state_dumper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  dump_base = '0;
    logic [8:0]  dump_len = '0;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    mips_state_dumper #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dump_base(dump_base), .dump_len(dump_len),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // register file r_i = i*3, synchronous-read data memory
    logic [31:0] mem_arr [256];
    logic [31:0] mem_q = '0;
    assign reg_rd_data = 32'(reg_rd_addr) * 32'd3;
    assign mem_rd_data = mem_q;
    always @(posedge clk) if (mem_rd_en) mem_q <= mem_arr[mem_addr];

    // scoreboard state
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [7:0]  addr_log[$];
    int   xfer_cnt, rd_cnt, last_cyc, first_valid_cyc, start_cyc;
    bit   seen_valid, stall_prev;
    logic [31:0] prev_data;
    logic        prev_last;

    // monitor: handshakes, stall stability, memory strobes
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                rd_cnt++;
                addr_log.push_back(mem_addr);
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            if (stall_prev) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got d=%h l=%b want no word", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        bad++;
                        $display("FAIL word_%0d: got d=%h l=%b want d=%h l=%b",
                                 xfer_cnt, out_data, out_last, e[31:0], e[32]);
                    end
                end
                xfer_cnt++;
                if (out_last) last_cyc = cyc;
            end
        end
    end

    task automatic start_dump(input logic [7:0] b, input logic [8:0] l);
        logic [7:0] a;
        exp_q.delete();
        addr_log.delete();
        xfer_cnt = 0; rd_cnt = 0; seen_valid = 1'b0; stall_prev = 1'b0;
        last_cyc = -100; first_valid_cyc = -100;
        for (int i = 0; i < 32; i++)
            exp_q.push_back({(l == 9'd0 && i == 31), 32'(i) * 32'd3});
        for (int j = 0; j < int'(l); j++) begin
            a = b + 8'(j);
            exp_q.push_back({(j == int'(l) - 1), mem_arr[a]});
        end
        @(posedge clk); #1;
        start = 1'b1; dump_base = b; dump_len = l; out_ready = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        dump_base = 8'($urandom);
        dump_len  = 9'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd, input bit poke);
        bit got = 1'b0;
        int done_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && (i == 40 || i == 90)) begin
                start = 1'b1; dump_base = 8'h55; dump_len = 9'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", budget);
        end
        total++;
        if (done_cyc !== last_cyc + 1) begin
            bad++;
            $display("FAIL done_timing: got cyc %0d want %0d", done_cyc, last_cyc + 1);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL words_left: got %0d unsent want 0", exp_q.size());
        end
        // start during DONE must be ignored
        start = 1'b1; dump_base = 8'h00; dump_len = 9'd1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: got busy=%b done=%b v=%b want 0 0 0", busy, done, out_valid);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        total++;
        if ({out_valid, out_last, busy, done, mem_rd_en} !== 5'b0 || mem_addr !== 8'h00 ||
            reg_rd_addr !== 5'h00 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL %s: got v=%b l=%b busy=%b done=%b rd=%b ma=%h ra=%h d=%h want all 0",
                     nm, out_valid, out_last, busy, done, mem_rd_en, mem_addr, reg_rd_addr, out_data);
        end
    endtask

    task automatic test_reset();
        #1;
        check_zero_outputs("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_dump(8'h10, 9'd4);
        wait_done(400, 1'b0, 1'b0);
        total++;
        if (xfer_cnt != 36) begin bad++; $display("FAIL basic_count: got %0d want 36", xfer_cnt); end
        total++;
        if (first_valid_cyc != start_cyc + 1) begin
            bad++;
            $display("FAIL first_latency: got cyc %0d want %0d", first_valid_cyc, start_cyc + 1);
        end
        total++;
        if (rd_cnt != 4) begin bad++; $display("FAIL basic_rd_en: got %0d want 4", rd_cnt); end
        total++;
        if (last_cyc - start_cyc != 2 * 32 + 3 * 4 - 1) begin
            bad++;
            $display("FAIL total_latency: got %0d want %0d", last_cyc - start_cyc, 2 * 32 + 3 * 4 - 1);
        end
    endtask

    task automatic test_len0();
        start_dump(8'h33, 9'd0);
        wait_done(400, 1'b0, 1'b0);
        total++;
        if (xfer_cnt != 32) begin bad++; $display("FAIL len0_count: got %0d want 32", xfer_cnt); end
        total++;
        if (rd_cnt != 0) begin bad++; $display("FAIL len0_rd_en: got %0d want 0", rd_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] want [4];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
        start_dump(8'hFE, 9'd4);
        wait_done(400, 1'b0, 1'b0);
        total++;
        if (addr_log.size() != 4) begin
            bad++;
            $display("FAIL wrap_count: got %0d reads want 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (addr_log[i] !== want[i]) begin
                    bad++;
                    $display("FAIL wrap_addr_%0d: got %h want %h", i, addr_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        start_dump(8'h10, 9'd4);
        wait_done(2000, 1'b1, 1'b0);
        total++;
        if (xfer_cnt != 36) begin bad++; $display("FAIL stall_count: got %0d want 36", xfer_cnt); end
    endtask

    task automatic test_busy_start();
        start_dump(8'h10, 9'd4);
        wait_done(400, 1'b0, 1'b1);
        total++;
        if (xfer_cnt != 36) begin bad++; $display("FAIL busy_start_count: got %0d want 36", xfer_cnt); end
    endtask

    task automatic test_full_len();
        start_dump(8'h80, 9'd256);
        wait_done(2000, 1'b0, 1'b0);
        total++;
        if (xfer_cnt != 288) begin bad++; $display("FAIL full_len_count: got %0d want 288", xfer_cnt); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        start_dump(8'h10, 9'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (xfer_cnt == 19) begin hit = 1'b1; break; end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL reset_mid_reach: got %0d words want 19", xfer_cnt); end
        rst = 1'b1;
        #1;
        check_zero_outputs("reset_mid_zero");
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        xfer_cnt = 0;
        repeat (3) @(negedge clk);
        total++;
        if (xfer_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: got words=%0d busy=%b want 0 0", xfer_cnt, busy);
        end
        start_dump(8'h10, 9'd4);
        wait_done(400, 1'b0, 1'b0);
        total++;
        if (xfer_cnt != 36) begin bad++; $display("FAIL restart_count: got %0d want 36", xfer_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_stall();
        test_busy_start();
        test_full_len();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
